fadd_acc: RTL and testbench



---
 rtl/fpu_pkg.sv | 19 +
 rtl/fadd.sv | 118 +++++++++++
 rtl/fadd_acc.sv | 98 +++++++++
 tb/tb_fadd_acc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and float32 constants.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } fadd_acc_state_t;

    localparam int FP32_SIGN_W = 1;
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_FRAC_W = 23;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
    localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = '1;

endpackage

// File: rtl/fadd.sv
// Combinational float32 adder, round-to-nearest-even, denormals supported.
// ovf flags a finite sum that rounds past the largest normal.
module fadd
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);

    logic                   s1, s2;
    logic [FP32_EXP_W-1:0]  e1, e2;
    logic [FP32_FRAC_W-1:0] f1, f2;
    logic                   nan1, nan2, inf1, inf2;
    logic                   swap, sl, ss;
    logic [7:0]             el, es, d;
    logic [23:0]            ml, ms;
    logic [4:0]             dsh, lz, k;
    logic [57:0]            wide;
    logic [26:0]            mla, msa, nrm;
    logic [27:0]            sum;
    logic [9:0]             e, em1, ep, ef;
    logic [24:0]            mr;
    logic                   rup;
    logic [22:0]            ff;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] r;
        r = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) r = 5'(26 - i);
        end
        return r;
    endfunction

    assign {s1, e1, f1} = x1;
    assign {s2, e2, f2} = x2;

    always_comb begin
        y    = FP32_POS_ZERO;
        ovf  = 1'b0;
        nan1 = (e1 == FP32_EXP_MAX) && (f1 != '0);
        nan2 = (e2 == FP32_EXP_MAX) && (f2 != '0);
        inf1 = (e1 == FP32_EXP_MAX) && (f1 == '0);
        inf2 = (e2 == FP32_EXP_MAX) && (f2 == '0);
        swap = x2[30:0] > x1[30:0];
        sl   = swap ? s2 : s1;
        ss   = swap ? s1 : s2;
        el   = swap ? ((e2 == '0) ? 8'd1 : e2) : ((e1 == '0) ? 8'd1 : e1);
        es   = swap ? ((e1 == '0) ? 8'd1 : e1) : ((e2 == '0) ? 8'd1 : e2);
        ml   = swap ? {e2 != '0, f2} : {e1 != '0, f1};
        ms   = swap ? {e1 != '0, f1} : {e2 != '0, f2};
        d    = el - es;
        // Beyond 31 places the smaller operand is sticky-only either way.
        dsh  = (d > 8'd31) ? 5'd31 : d[4:0];
        wide = {ms, 34'd0} >> dsh;
        mla  = {ml, 3'b000};
        msa  = {wide[57:32], wide[31] | (|wide[30:0])};
        sum  = (sl == ss) ? ({1'b0, mla} + {1'b0, msa}) : ({1'b0, mla} - {1'b0, msa});
        e    = {2'b00, el};
        em1  = '0;
        lz   = '0;
        k    = '0;
        nrm  = '0;
        ep   = '0;
        rup  = 1'b0;
        mr   = '0;
        ef   = '0;
        ff   = '0;

        if (nan1) begin
            y = x1 | 32'h0040_0000;
        end else if (nan2) begin
            y = x2 | 32'h0040_0000;
        end else if (inf1 && inf2 && (s1 != s2)) begin
            y = FP32_QNAN;
        end else if (inf1) begin
            y = x1;
        end else if (inf2) begin
            y = x2;
        end else if (sum == '0) begin
            y = {s1 & s2, 31'd0};
        end else begin
            if (sum[27]) begin
                nrm = {sum[27:2], sum[1] | sum[0]};
                e   = e + 10'd1;
            end else begin
                // Left shift is clamped so the exponent bottoms out at the denormal scale.
                lz  = lzc27(sum[26:0]);
                em1 = e - 10'd1;
                k   = ({5'd0, lz} > em1) ? em1[4:0] : lz;
                nrm = sum[26:0] << k;
                e   = e - {5'd0, k};
            end
            ep  = nrm[26] ? e : 10'd0;
            rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
            mr  = {1'b0, nrm[26:3]} + {24'd0, rup};
            if (mr[24]) begin
                ef = ep + 10'd1;
                ff = mr[23:1];
            end else if ((ep == '0) && mr[23]) begin
                ef = 10'd1;
                ff = mr[22:0];
            end else begin
                ef = ep;
                ff = mr[22:0];
            end
            if (ef >= 10'd255) begin
                y   = {sl, FP32_EXP_MAX, 23'd0};
                ovf = 1'b1;
            end else begin
                y = {sl, ef[7:0], ff};
            end
        end
    end

endmodule

// File: rtl/fadd_acc.sv
// Streaming float32 accumulator: sums len terms through fadd, returns sum and sticky overflow.
//   state | meaning
//   IDLE  | waiting for start
//   FIRST | first term loads acc verbatim
//   ACC   | remaining terms summed through fadd
//   DONE  | result held until out_ready
module fadd_acc
    import fpu_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_ovf
);

    fadd_acc_state_t state, state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      acc;
    logic             ovf_r;
    logic [31:0]      sum_y;
    logic             sum_ovf;
    logic             take;
    logic             last;

    fadd u_fadd (
        .x1  (acc),
        .x2  (in_data),
        .y   (sum_y),
        .ovf (sum_ovf)
    );

    assign busy      = (state != IDLE);
    assign in_ready  = (state == FIRST) || (state == ACC);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_ovf   = ovf_r;
    assign take      = in_valid && in_ready;
    assign last      = (cnt == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (len != '0) ? FIRST : DONE;
            FIRST: if (in_valid) state_nxt = last ? DONE : ACC;
            ACC:   if (in_valid && last) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= FP32_POS_ZERO;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= len;
                        ovf_r <= 1'b0;
                        if (len == '0) acc <= FP32_POS_ZERO;
                    end
                end
                FIRST: begin
                    if (take) begin
                        acc <= in_data;
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                ACC: begin
                    if (take) begin
                        acc   <= sum_y;
                        ovf_r <= ovf_r | sum_ovf;
                        cnt   <= cnt - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_acc.sv
// Directed self-checking bench for fadd_acc.
module tb_fadd_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    fadd_acc #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic push(input string tag, input logic [31:0] d);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [31:0] ed, input logic eo,
                               input logic check_data);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (check_data) chk({tag, "_data"}, out_data, ed);
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
        chk({tag, "_inready"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_inready", 32'(in_ready), 32'd0);
        chk("rst_outvalid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        tick();

        // Basic sum 1+2+3, back-to-back, latency check
        start_job(8'd3);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_first_ready", 32'(in_ready), 32'd1);
        push("basic0", 32'h3F80_0000);
        push("basic1", 32'h4000_0000);
        chk("basic_not_done", 32'(out_valid), 32'd0);
        push("basic2", 32'h4040_0000);
        chk("basic_latency", 32'(out_valid), 32'd1);
        take_result("basic", 32'h40C0_0000, 1'b0, 1'b1);

        // Overflow to infinity
        start_job(8'd2);
        push("ovf0", 32'h7F7F_FFFF);
        push("ovf1", 32'h7F7F_FFFF);
        take_result("ovf", 32'h7F80_0000, 1'b1, 1'b1);

        // Sticky: inf + -inf afterwards does not clear the flag
        start_job(8'd3);
        push("sticky0", 32'h7F7F_FFFF);
        push("sticky1", 32'h7F7F_FFFF);
        push("sticky2", 32'hFF80_0000);
        take_result("sticky", 32'h0, 1'b1, 1'b0);

        // Zero length: result next cycle, ovf cleared from previous job
        start_job(8'd0);
        chk("zero_latency", 32'(out_valid), 32'd1);
        take_result("zero", 32'h0000_0000, 1'b0, 1'b1);

        // Single terms pass through unmodified
        start_job(8'd1);
        push("negzero", 32'h8000_0000);
        take_result("negzero", 32'h8000_0000, 1'b0, 1'b1);

        start_job(8'd1);
        push("nan", 32'h7FC0_0001);
        take_result("nan", 32'h7FC0_0001, 1'b0, 1'b1);

        // Rounding ties-to-even and just-above-tie
        start_job(8'd2);
        push("tie0", 32'h3F80_0000);
        push("tie1", 32'h3380_0000);
        take_result("tie", 32'h3F80_0000, 1'b0, 1'b1);

        start_job(8'd2);
        push("up0", 32'h3F80_0000);
        push("up1", 32'h3380_0001);
        take_result("roundup", 32'h3F80_0001, 1'b0, 1'b1);

        // Signed zero rules
        start_job(8'd2);
        push("cancel0", 32'h3F80_0000);
        push("cancel1", 32'hBF80_0000);
        take_result("cancel", 32'h0000_0000, 1'b0, 1'b1);

        start_job(8'd2);
        push("nz0", 32'h8000_0000);
        push("nz1", 32'h8000_0000);
        take_result("negzero_sum", 32'h8000_0000, 1'b0, 1'b1);

        // Gapped input then back-pressured output, start pulses ignored
        start_job(8'd4);
        in_data = 32'h3F80_0000;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 8'd2;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, 32'h4080_0000);
            chk("bp_inready", 32'(in_ready), 32'd0);
            tick();
        end
        start = 1'b0;
        len   = '0;
        take_result("bp", 32'h4080_0000, 1'b0, 1'b1);
        tick();
        chk("bp_still_idle", 32'(busy), 32'd0);

        // Reset mid-job discards progress
        start_job(8'd4);
        push("mid0", 32'h3F80_0000);
        push("mid1", 32'h3F80_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_inready", 32'(in_ready), 32'd0);
        chk("mid_outvalid", 32'(out_valid), 32'd0);
        chk("mid_data", out_data, 32'h0);
        chk("mid_ovf", 32'(out_ovf), 32'd0);
        start_job(8'd1);
        push("after", 32'h4000_0000);
        take_result("after_rst", 32'h4000_0000, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
